// File: rtl/timeset_pkg.sv
// Shared encodings and BCD limits for the time-set controller.
package timeset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam logic [7:0] BCD_MAX_60 = 8'h59;
  localparam logic [7:0] BCD_MAX_24 = 8'h23;

  // Hold counter width; sized for a repeat delay of up to 15 ticks.
  localparam int CNT_W = 4;

endpackage

// File: rtl/timeset_ctrl_if.sv
// Button/load/display bundle between a front panel and timeset_ctrl.
interface timeset_ctrl_if #(
  parameter int NF = 3
);
  localparam int SELW = (NF > 1) ? $clog2(NF) : 1;

  logic            TICK;
  logic            UP;
  logic            DOWN;
  logic [SELW-1:0] SEL;
  logic            PE;
  logic [8*NF-1:0] D;
  logic [8*NF-1:0] Q;
  logic            STEP;
  logic            RPT;

  modport master (output TICK, UP, DOWN, SEL, PE, D, input Q, STEP, RPT);
  modport slave  (input TICK, UP, DOWN, SEL, PE, D, output Q, STEP, RPT);

endinterface

// File: rtl/timeset_bcd2_field.sv
// One 2-digit BCD register that wraps between 00 and MAX in either direction.
module bcd2_field #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       LD,
  input  logic [7:0] D,
  input  logic       INC,
  input  logic       DEC,
  output logic [7:0] Q
);

  logic [7:0] q_q, q_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == MAX)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)        return MAX;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Out-of-range or non-BCD load data collapses to zero so Q is always legal.
  function automatic logic [7:0] bcd_load(input logic [7:0] v);
    if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > MAX)) return 8'h00;
    return v;
  endfunction

  always_comb begin
    q_d = q_q;
    if (LD)                q_d = bcd_load(D);
    else if (INC && !DEC)  q_d = bcd_inc(q_q);
    else if (DEC && !INC)  q_d = bcd_dec(q_q);
  end

  always_ff @(posedge CP) begin
    if (!CR) q_q <= 8'h00;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/timeset_ctrl.sv
// Clock/time setting controller: one step per press, auto-repeat on TICK after a hold delay.
module timeset_ctrl
  import timeset_pkg::*;
#(
  parameter int              NF      = 3,
  parameter logic [8*NF-1:0] MAX_VEC = {BCD_MAX_24, BCD_MAX_60, BCD_MAX_60},
  parameter int              RPT_DLY = 3
) (
  input  logic           CP,
  input  logic           CR,
  timeset_ctrl_if.slave  bus
);

  localparam int               SELW     = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [SELW:0]    NF_L     = (SELW + 1)'(NF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RPT_DLY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              rpt_q, rpt_d;
  logic              do_step;
  logic              req_valid;
  logic              req_same;
  logic [8*NF-1:0]   q_w;

  assign req_valid = (bus.UP ^ bus.DOWN) && ({1'b0, bus.SEL} < NF_L);
  // Any change of direction or field versus the latched press ends the sequence.
  assign req_same  = req_valid && (bus.UP == dir_q) && (bus.SEL == sel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    if (bus.PE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            do_step = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = '0;
            sel_d   = bus.SEL;
            dir_d   = bus.UP;
          end
        end
        ST_HOLD: begin
          if (!req_same) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (bus.TICK) begin
            if (cnt_q == CNT_LAST) state_d = ST_REPEAT;
            else                   cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!req_same) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (bus.TICK) begin
            do_step = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    step_d = do_step;
    rpt_d  = (state_d == ST_REPEAT);
  end

  always_ff @(posedge CP) begin
    if (!CR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      rpt_q   <= rpt_d;
    end
  end

  for (genvar i = 0; i < NF; i++) begin : g_field
    localparam logic [SELW-1:0] IDX = SELW'(i);
    logic hit;
    assign hit = do_step && (sel_d == IDX);
    bcd2_field #(.MAX(MAX_VEC[8*i +: 8])) u_field (
      .CP  (CP),
      .CR  (CR),
      .LD  (bus.PE),
      .D   (bus.D[8*i +: 8]),
      .INC (hit && dir_d),
      .DEC (hit && !dir_d),
      .Q   (q_w[8*i +: 8])
    );
  end

  assign bus.Q    = q_w;
  assign bus.STEP = step_q;
  assign bus.RPT  = rpt_q;

endmodule
